ifm_rx_ingress: RTL and testbench

Parametrised receive-side ingress stage between the MAC RX AXI-Stream and the ingress data/info FIFOs. It accepts frames beat by beat and writes them to the data FIFO. Each accepted frame produces one info word holding its status and byte length. Whole frames are dropped when FIFO space is short at frame start, oversize frames are truncated, and accept/error/drop events are counted in saturating statistics counters.

---
 rtl/ifm_rx_ingress.sv | 157 +++++++++++++++
 tb/tb_ifm_rx_ingress.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_rx_ingress.sv
// MAC RX ingress: moves AXI-Stream beats into the data FIFO, emits one info word per
// admitted frame, drops whole frames when FIFO space is short, and truncates oversize frames.
//
// state  | meaning
// S_IDLE | between frames; the next valid beat is a first beat
// S_PASS | admitted frame in progress, every beat is written
// S_DROP | discarding the rest of a dropped or truncated frame
module ifm_rx_ingress #(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_KEEP_WIDTH = C_DATA_WIDTH/8,
  parameter int C_LEN_WIDTH  = 16,
  parameter int C_MAX_BYTES  = 9600,
  parameter int C_CNT_WIDTH  = 32
) (
  input  logic                                rx_clk,
  input  logic                                rx_reset,
  input  logic [C_DATA_WIDTH-1:0]             rx_axis_mac_tdata,
  input  logic [C_KEEP_WIDTH-1:0]             rx_axis_mac_tkeep,
  input  logic                                rx_axis_mac_tlast,
  input  logic                                rx_axis_mac_tuser,
  input  logic                                rx_axis_mac_tvalid,
  output logic                                rx_axis_mac_tready,
  output logic [C_DATA_WIDTH+C_KEEP_WIDTH:0]  data_fifo_wdata,
  output logic                                data_fifo_wren,
  input  logic                                data_fifo_afull,
  output logic [C_LEN_WIDTH+1:0]              info_fifo_wdata,
  output logic                                info_fifo_wren,
  input  logic                                info_fifo_full,
  output logic [C_CNT_WIDTH-1:0]              stat_frames_ok,
  output logic [C_CNT_WIDTH-1:0]              stat_frames_bad,
  output logic [C_CNT_WIDTH-1:0]              stat_frames_drop,
  input  logic                                stat_clear
);

  localparam int BCW = C_LEN_WIDTH + 1;
  localparam int BBW = $clog2(C_KEEP_WIDTH + 1);
  localparam logic [BCW-1:0] MAX_CNT_C =
    (C_MAX_BYTES >= (1 << BCW)) ? {BCW{1'b1}} : BCW'(C_MAX_BYTES);
  localparam logic [C_LEN_WIDTH-1:0] MAX_LEN_C =
    (C_MAX_BYTES >= (1 << C_LEN_WIDTH)) ? {C_LEN_WIDTH{1'b1}} : C_LEN_WIDTH'(C_MAX_BYTES);
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE_C = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

  state_t                 state, state_nxt;
  logic [BCW-1:0]         byte_cnt, byte_cnt_nxt, cnt_prior, cnt_new;
  logic [BCW:0]           cnt_sum;
  logic [BBW-1:0]         beat_bytes;
  logic [C_LEN_WIDTH-1:0] len_field, info_len;
  logic                   pass_beat, data_wr, force_last;
  logic                   info_wr, info_good, info_trunc;
  logic                   inc_ok, inc_bad, inc_drop;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < C_KEEP_WIDTH; i++)
      beat_bytes = beat_bytes + BBW'(rx_axis_mac_tkeep[i]);
  end

  // A first beat counts from zero, so the count needs no explicit clear between frames.
  assign cnt_prior = (state == S_IDLE) ? '0 : byte_cnt;
  assign cnt_sum   = {1'b0, cnt_prior} + (BCW+1)'(beat_bytes);
  assign cnt_new   = cnt_sum[BCW] ? {BCW{1'b1}} : cnt_sum[BCW-1:0];
  assign len_field = cnt_new[BCW-1] ? {C_LEN_WIDTH{1'b1}} : cnt_new[C_LEN_WIDTH-1:0];

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    pass_beat    = 1'b0;
    data_wr      = 1'b0;
    force_last   = 1'b0;
    info_wr      = 1'b0;
    info_good    = 1'b0;
    info_trunc   = 1'b0;
    info_len     = '0;
    inc_ok       = 1'b0;
    inc_bad      = 1'b0;
    inc_drop     = 1'b0;
    if (rx_axis_mac_tvalid) begin
      unique case (state)
        S_IDLE: begin
          if (data_fifo_afull || info_fifo_full) begin
            inc_drop  = 1'b1;
            state_nxt = rx_axis_mac_tlast ? S_IDLE : S_DROP;
          end else begin
            pass_beat = 1'b1;
            state_nxt = S_PASS;
          end
        end
        S_PASS: pass_beat = 1'b1;
        S_DROP: if (rx_axis_mac_tlast) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase

      if (pass_beat) begin
        data_wr      = 1'b1;
        byte_cnt_nxt = cnt_new;
        // Once the limit is reached any further beat would overflow, so cut the frame here.
        if (!rx_axis_mac_tlast && cnt_new >= MAX_CNT_C) begin
          force_last = 1'b1;
          info_wr    = 1'b1;
          info_trunc = 1'b1;
          info_len   = MAX_LEN_C;
          inc_bad    = 1'b1;
          state_nxt  = S_DROP;
        end else if (rx_axis_mac_tlast) begin
          info_wr   = 1'b1;
          info_good = rx_axis_mac_tuser && (cnt_new <= MAX_CNT_C);
          info_len  = len_field;
          inc_ok    = info_good;
          inc_bad   = !info_good;
          state_nxt = S_IDLE;
        end
      end
    end
  end

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v,
                                                     input logic inc);
    return (inc && (v != {C_CNT_WIDTH{1'b1}})) ? v + CNT_ONE_C : v;
  endfunction

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state              <= S_IDLE;
      byte_cnt           <= '0;
      rx_axis_mac_tready <= 1'b0;
      data_fifo_wren     <= 1'b0;
      data_fifo_wdata    <= '0;
      info_fifo_wren     <= 1'b0;
      info_fifo_wdata    <= '0;
      stat_frames_ok     <= '0;
      stat_frames_bad    <= '0;
      stat_frames_drop   <= '0;
    end else begin
      state              <= state_nxt;
      byte_cnt           <= byte_cnt_nxt;
      rx_axis_mac_tready <= 1'b1;
      data_fifo_wren     <= data_wr;
      info_fifo_wren     <= info_wr;
      if (data_wr)
        data_fifo_wdata <= {rx_axis_mac_tlast | force_last, rx_axis_mac_tkeep, rx_axis_mac_tdata};
      if (info_wr)
        info_fifo_wdata <= {info_good, info_trunc, info_len};
      if (stat_clear) begin
        stat_frames_ok   <= '0;
        stat_frames_bad  <= '0;
        stat_frames_drop <= '0;
      end else begin
        stat_frames_ok   <= sat_inc(stat_frames_ok, inc_ok);
        stat_frames_bad  <= sat_inc(stat_frames_bad, inc_bad);
        stat_frames_drop <= sat_inc(stat_frames_drop, inc_drop);
      end
    end
  end

endmodule

// File: tb/tb_ifm_rx_ingress.sv
// Self-checking bench for ifm_rx_ingress: frame-level reference model feeds expected-write
// queues that a negedge monitor scores; each test task checks counters and completeness.
module tb_ifm_rx_ingress;
  localparam int DW = 64, KW = 8, LW = 16, MAXB = 64, CW = 32;

  logic               rx_clk = 1'b0;
  logic               rx_reset;
  logic [DW-1:0]      rx_axis_mac_tdata;
  logic [KW-1:0]      rx_axis_mac_tkeep;
  logic               rx_axis_mac_tlast, rx_axis_mac_tuser, rx_axis_mac_tvalid, rx_axis_mac_tready;
  logic [DW+KW:0]     data_fifo_wdata;
  logic               data_fifo_wren, data_fifo_afull;
  logic [LW+1:0]      info_fifo_wdata;
  logic               info_fifo_wren, info_fifo_full;
  logic [CW-1:0]      stat_frames_ok, stat_frames_bad, stat_frames_drop;
  logic               stat_clear;

  ifm_rx_ingress #(.C_DATA_WIDTH(DW), .C_LEN_WIDTH(LW), .C_MAX_BYTES(MAXB), .C_CNT_WIDTH(CW)) dut (
    .rx_clk(rx_clk), .rx_reset(rx_reset),
    .rx_axis_mac_tdata(rx_axis_mac_tdata), .rx_axis_mac_tkeep(rx_axis_mac_tkeep),
    .rx_axis_mac_tlast(rx_axis_mac_tlast), .rx_axis_mac_tuser(rx_axis_mac_tuser),
    .rx_axis_mac_tvalid(rx_axis_mac_tvalid), .rx_axis_mac_tready(rx_axis_mac_tready),
    .data_fifo_wdata(data_fifo_wdata), .data_fifo_wren(data_fifo_wren),
    .data_fifo_afull(data_fifo_afull), .info_fifo_wdata(info_fifo_wdata),
    .info_fifo_wren(info_fifo_wren), .info_fifo_full(info_fifo_full),
    .stat_frames_ok(stat_frames_ok), .stat_frames_bad(stat_frames_bad),
    .stat_frames_drop(stat_frames_drop), .stat_clear(stat_clear));

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int exp_ok = 0, exp_bad = 0, exp_drop = 0;
  logic [DW+KW:0] exp_data_q[$];
  int             exp_data_cyc[$];
  logic [LW+1:0]  exp_info_q[$];
  int             exp_info_cyc[$];

  // Scoreboard: every write must match the next expected write, on the expected cycle.
  always @(negedge rx_clk) begin
    if (data_fifo_wren === 1'b1) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL data_write: got unexpected write %h at cycle %0d, required no write", data_fifo_wdata, cyc);
      end else begin
        logic [DW+KW:0] e; int ec;
        e = exp_data_q.pop_front(); ec = exp_data_cyc.pop_front();
        if (data_fifo_wdata !== e || cyc !== ec) begin
          errors++;
          $display("FAIL data_write: got %h at cycle %0d, required %h at cycle %0d", data_fifo_wdata, cyc, e, ec);
        end
      end
    end
    if (info_fifo_wren === 1'b1) begin
      checks++;
      if (exp_info_q.size() == 0) begin
        errors++;
        $display("FAIL info_write: got unexpected write %h at cycle %0d, required no write", info_fifo_wdata, cyc);
      end else begin
        logic [LW+1:0] e; int ec;
        e = exp_info_q.pop_front(); ec = exp_info_cyc.pop_front();
        if (info_fifo_wdata !== e || cyc !== ec) begin
          errors++;
          $display("FAIL info_write: got %h at cycle %0d, required %h at cycle %0d", info_fifo_wdata, cyc, e, ec);
        end
      end
    end
  end

  task automatic idle(input int n);
    rx_axis_mac_tvalid = 1'b0;
    rx_axis_mac_tlast  = 1'b0;
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  // Drives one frame and records what the ingress stage should produce for it:
  // admitted frames are copied beat by beat until the byte limit is reached without tlast.
  task automatic send_frame(input int nbeats, input int last_bytes, input bit tuser,
                            input int gap_max, input bit afull0, input bit full0);
    bit done;
    int total;
    done  = afull0 || full0;
    total = 0;
    if (done) exp_drop++;
    for (int i = 0; i < nbeats; i++) begin
      bit last; int nb; logic [KW-1:0] k; logic [DW-1:0] d;
      last = (i == nbeats - 1);
      nb   = last ? last_bytes : KW;
      k    = KW'((1 << nb) - 1);
      d    = {$urandom, $urandom};
      if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
      rx_axis_mac_tdata  = d;
      rx_axis_mac_tkeep  = k;
      rx_axis_mac_tlast  = last;
      rx_axis_mac_tuser  = last ? tuser : 1'($urandom);
      rx_axis_mac_tvalid = 1'b1;
      data_fifo_afull    = (i == 0) ? afull0 : 1'($urandom);
      info_fifo_full     = (i == 0) ? full0  : 1'($urandom);
      if (!done) begin
        total += nb;
        if (!last && total >= MAXB) begin
          exp_data_q.push_back({1'b1, k, d}); exp_data_cyc.push_back(cyc + 1);
          exp_info_q.push_back({1'b0, 1'b1, LW'(MAXB)}); exp_info_cyc.push_back(cyc + 1);
          exp_bad++;
          done = 1;
        end else begin
          exp_data_q.push_back({last, k, d}); exp_data_cyc.push_back(cyc + 1);
          if (last) begin
            bit good;
            good = tuser && (total <= MAXB);
            exp_info_q.push_back({good, 1'b0, LW'(total)}); exp_info_cyc.push_back(cyc + 1);
            if (good) exp_ok++; else exp_bad++;
          end
        end
      end
      @(posedge rx_clk); #1;
    end
    rx_axis_mac_tvalid = 1'b0;
    rx_axis_mac_tlast  = 1'b0;
    data_fifo_afull    = 1'b0;
    info_fifo_full     = 1'b0;
  endtask

  task automatic test_reset;
    rx_reset = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1;
    checks++;
    if ({rx_axis_mac_tready, data_fifo_wren, info_fifo_wren, data_fifo_wdata, info_fifo_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tready=%b dwren=%b iwren=%b dwdata=%h iwdata=%h, required all 0",
               rx_axis_mac_tready, data_fifo_wren, info_fifo_wren, data_fifo_wdata, info_fifo_wdata);
    end
    checks++;
    if ({stat_frames_ok, stat_frames_bad, stat_frames_drop} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got ok=%0d bad=%0d drop=%0d, required 0 0 0", stat_frames_ok, stat_frames_bad, stat_frames_drop);
    end
    rx_reset = 1'b0;
    @(posedge rx_clk); #1;
    checks++;
    if (rx_axis_mac_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %b, required 1", rx_axis_mac_tready);
    end
  endtask

  task automatic check_state(input string name);
    idle(2);
    checks++;
    if (exp_data_q.size() != 0 || exp_info_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d data and %0d info writes outstanding, required 0 0", name, exp_data_q.size(), exp_info_q.size());
      exp_data_q.delete(); exp_data_cyc.delete(); exp_info_q.delete(); exp_info_cyc.delete();
    end
    checks++;
    if (stat_frames_ok !== CW'(exp_ok) || stat_frames_bad !== CW'(exp_bad) || stat_frames_drop !== CW'(exp_drop)) begin
      errors++;
      $display("FAIL %s_counters: got ok=%0d bad=%0d drop=%0d, required %0d %0d %0d", name,
               stat_frames_ok, stat_frames_bad, stat_frames_drop, exp_ok, exp_bad, exp_drop);
    end
  endtask

  task automatic test_basic;
    send_frame(3, 4, 1'b1, 0, 1'b0, 1'b0);
    check_state("basic");
  endtask

  task automatic test_drop;
    send_frame(4, 8, 1'b1, 0, 1'b1, 1'b0);
    send_frame(2, 5, 1'b1, 0, 1'b0, 1'b1);
    send_frame(2, 6, 1'b1, 0, 1'b0, 1'b0);
    check_state("drop");
  endtask

  task automatic test_truncate;
    send_frame(12, 8, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8, 8, 1'b1, 0, 1'b0, 1'b0);
    check_state("truncate");
  endtask

  task automatic test_bad_gaps;
    send_frame(5, 3, 1'b0, 3, 1'b0, 1'b0);
    check_state("bad_gaps");
  endtask

  task automatic test_back_to_back;
    send_frame(1, 1, 1'b1, 0, 1'b0, 1'b0);
    send_frame(3, 8, 1'b1, 0, 1'b0, 1'b0);
    send_frame(1, 7, 1'b0, 0, 1'b0, 1'b0);
    check_state("back_to_back");
  endtask

  task automatic test_random;
    for (int f = 0; f < 40; f++) begin
      send_frame($urandom_range(1, 10), $urandom_range(1, KW), 1'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    check_state("random");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 2; i++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom};
      rx_axis_mac_tdata = d; rx_axis_mac_tkeep = '1; rx_axis_mac_tlast = 1'b0; rx_axis_mac_tvalid = 1'b1;
      exp_data_q.push_back({1'b0, {KW{1'b1}}, d}); exp_data_cyc.push_back(cyc + 1);
      @(posedge rx_clk); #1;
    end
    rx_reset = 1'b1;
    @(posedge rx_clk); #1;
    exp_ok = 0; exp_bad = 0; exp_drop = 0;
    checks++;
    if ({rx_axis_mac_tready, data_fifo_wren, info_fifo_wren, data_fifo_wdata, info_fifo_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got tready=%b dwren=%b iwren=%b dwdata=%h iwdata=%h, required all 0",
               rx_axis_mac_tready, data_fifo_wren, info_fifo_wren, data_fifo_wdata, info_fifo_wdata);
    end
    rx_axis_mac_tvalid = 1'b0;
    rx_reset = 1'b0;
    @(posedge rx_clk); #1;
    checks++;
    if (rx_axis_mac_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_tready: got %b, required 1", rx_axis_mac_tready);
    end
    send_frame(2, 3, 1'b1, 0, 1'b0, 1'b0);
    check_state("reset_mid");
  endtask

  task automatic test_stat_clear;
    send_frame(1, 2, 1'b0, 0, 1'b0, 1'b0);
    stat_clear = 1'b1;
    send_frame(1, 2, 1'b1, 0, 1'b0, 1'b0);
    stat_clear = 1'b0;
    exp_ok = 0; exp_bad = 0; exp_drop = 0;
    checks++;
    if ({stat_frames_ok, stat_frames_bad, stat_frames_drop} !== '0) begin
      errors++;
      $display("FAIL stat_clear_wins: got ok=%0d bad=%0d drop=%0d, required 0 0 0", stat_frames_ok, stat_frames_bad, stat_frames_drop);
    end
    send_frame(2, 4, 1'b0, 0, 1'b0, 1'b0);
    send_frame(3, 1, 1'b1, 0, 1'b1, 1'b0);
    check_state("stat_clear");
  endtask

  initial begin
    rx_reset = 1'b1; stat_clear = 1'b0;
    rx_axis_mac_tdata = '0; rx_axis_mac_tkeep = '0; rx_axis_mac_tlast = 1'b0;
    rx_axis_mac_tuser = 1'b0; rx_axis_mac_tvalid = 1'b0;
    data_fifo_afull = 1'b0; info_fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_drop();
    test_truncate();
    test_bad_gaps();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_stat_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
